// File: rtl/mod_addsub_ws.sv
// rtl/mod_addsub_ws.sv - word-serial modular add/subtract with single conditional correction
// Both candidates (S and corrected D) are buffered; the final carry/borrow picks one for readout.
module mod_addsub_ws #(
  parameter int K = 256,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         in_valid,
  input  logic [K-1:0] in_x,
  input  logic [K-1:0] in_y,
  input  logic [K-1:0] in_m,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  output logic         busy
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, state_nx;

  logic          mode_r, c, b, sel;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          rd_v, rd_l;
  logic [K-1:0]  s_q, d_q;
  logic [K-1:0]  s_buf [N];
  logic [K-1:0]  d_buf [N];

  logic          start_acc, word_acc, last_word, rd_issue;
  logic [K:0]    t_a, t_b;
  logic [K-1:0]  s_w, d_w;
  logic          c_nx, b_nx;

  assign start_acc = (state == IDLE) && start;
  assign word_acc  = (state == LOAD) && in_valid;
  assign last_word = word_acc && (wr_cnt == LAST_IDX);
  assign rd_issue  = (state == DRAIN) && !rd_l;

  // Add: S = X+Y, D = S-M.  Sub: S = X-Y, D = S+M.
  always_comb begin
    if (!mode_r) begin
      t_a  = {1'b0, in_x} + {1'b0, in_y} + {{K{1'b0}}, c};
      s_w  = t_a[K-1:0];
      c_nx = t_a[K];
      t_b  = {1'b0, s_w} - {1'b0, in_m} - {{K{1'b0}}, b};
      d_w  = t_b[K-1:0];
      b_nx = t_b[K];
    end else begin
      t_a  = {1'b0, in_x} - {1'b0, in_y} - {{K{1'b0}}, b};
      s_w  = t_a[K-1:0];
      b_nx = t_a[K];
      t_b  = {1'b0, s_w} + {1'b0, in_m} + {{K{1'b0}}, c};
      d_w  = t_b[K-1:0];
      c_nx = t_b[K];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (in_valid && wr_cnt == LAST_IDX) state_nx = DRAIN;
      DRAIN:   if (rd_l) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= 1'b0;
      c         <= 1'b0;
      b         <= 1'b0;
      sel       <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_v      <= 1'b0;
      rd_l      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (start_acc) begin
        mode_r <= mode;
        c      <= 1'b0;
        b      <= 1'b0;
        sel    <= 1'b0;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
      if (word_acc) begin
        c      <= c_nx;
        b      <= b_nx;
        wr_cnt <= last_word ? '0 : wr_cnt + 1'b1;
      end
      if (last_word) sel <= mode_r ? b_nx : (c_nx | ~b_nx);
      if (rd_issue) rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
      // Two-stage readout: RAM read register, then output select register.
      rd_v      <= rd_issue;
      rd_l      <= rd_issue && (rd_cnt == LAST_IDX);
      out_valid <= rd_v;
      out_last  <= rd_l;
      if (rd_v) out_data <= sel ? d_q : s_q;
      if (start_acc)     busy <= 1'b1;
      else if (out_last) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (word_acc) begin
      s_buf[wr_cnt] <= s_w;
      d_buf[wr_cnt] <= d_w;
    end
    if (rd_issue) begin
      s_q <= s_buf[rd_cnt];
      d_q <= d_buf[rd_cnt];
    end
  end

endmodule

// File: doc/mod_addsub_ws.md
# mod_addsub_ws

Word-serial modular adder/subtractor for the Paillier datapath. It sits beside the IDDMM exponentiation core and uses the same LSW-first K-bit word streaming. It computes (X+Y) mod M or (X−Y) mod M on N-word operands with a single conditional correction. Both candidate results are buffered internally, and the correct one is streamed out without backpressure.

## Interface
Parameters:
- K, 256, word width in bits
- N, 16, words per operand; operand width is K*N
- CW, $clog2(N), word counter width (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- mode  in  1  sampled with start: 0 = add, 1 = subtract
- in_valid  in  1  in_x/in_y/in_m word valid; accepted only in LOAD
- in_x  in  K  operand X word, LSW first
- in_y  in  K  operand Y word, LSW first
- in_m  in  K  modulus M word, LSW first
- out_data  out  K  result word, LSW first
- out_valid  out  1  out_data valid
- out_last  out  1  high with the final (MSW) result word
- busy  out  1  high from LOAD entry until the last output word

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE -> LOAD on start:
  - latch mode
  - clear carry c, borrow b, word index wr_cnt
- LOAD, per cycle with in_valid=1, at word i = wr_cnt:
  - add mode:
    - {c', s_i} = x_i + y_i + c
    - {b', d_i} = s_i − m_i − b, with borrow out
  - sub mode:
    - {b', s_i} = x_i − y_i − b, with borrow out
    - {c', d_i} = s_i + m_i + c
  - write s_i to buffer S[i] and d_i to buffer D[i]
  - update c, b; increment wr_cnt
  - in_valid=0 stalls with no state change
- Exit from LOAD: on the accepted word at wr_cnt = N−1, compute the select flag sel from the final carry/borrow (including that word), then go to DRAIN.
  - add: sel = c_final | ~b_final (S ≥ M, so output D)
  - sub: sel = b_final (X < Y, so output D = S + M)
  - sel=0: output S
- DRAIN: read word rd_cnt from the selected buffer for rd_cnt = 0..N−1, registered, so out_valid is high for N consecutive cycles. out_last accompanies rd_cnt = N−1. Return to IDLE after the last word.
- Buffers: two N×K arrays, inferable as simple dual-port RAM with one write port and one registered read port.
- Preconditions: X < M and Y < M. Otherwise the output is the single-correction value and no error is flagged.
- Width rules: carry and borrow are each 1 bit per word step; no other state wider than K+1.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, state=IDLE, counters and c/b/sel = 0. Buffer contents are don't-care.
- busy rises on the edge that samples start and falls on the edge after out_last is presented.
- Latency: if the last input word is sampled at edge T, the first result word is valid after edge T+2 and the last after edge T+N+1.
- No backpressure; the consumer must accept every out_valid cycle.
- Boundary conditions:
  - start while busy: ignored.
  - start and in_valid in the same IDLE cycle: the data word is ignored; words count only from LOAD.
  - in_valid in DRAIN or IDLE: ignored.
  - mode changes after start: no effect on the current operation.
  - rst asserted mid-LOAD or mid-DRAIN: immediately return to reset values; any partial output is abandoned.
  - Back-to-back: a start on the cycle after out_last is accepted.

## Test plan
Configuration K=8, N=4 unless stated. Each operand is given as a 32-bit value, streamed LSW byte first.
- Add, no wrap: X=0x12345678, Y=0x11111111, M=0xF0000001 -> output words 0x89,0x67,0x45,0x23; out_last on 0x23; first word valid at T+2.
- Add, sum ≥ M without carry-out: X=0xF0000000, Y=0x00000010, M=0xF0000001 -> 0x0F,0x00,0x00,0x00.
- Add, final carry-out: X=0xFFFFFFF0, Y=0xFFFFFFF0, M=0xFFFFFFF1 -> 0xEF,0xFF,0xFF,0xFF.
- Sub with borrow (X<Y): X=0x00000005, Y=0x00000007, M=0xF0000001 -> 0xFF,0xFF,0xFF,0xEF.
- Sub, no borrow, with gaps: X=0x12345678, Y=0x02345678, in_valid low for 3 cycles between words 1 and 2 -> 0x00,0x00,0x00,0x10, still at T+2 relative to the last word. A start pulse during DRAIN is ignored.
- Reset and regression:
  - rst pulsed after 2 words of LOAD -> all outputs return to 0 and busy=0; the next full operation is correct.
  - Default K=256, N=16: 1000 random add/sub operations with X,Y < M match the software model bit-exactly.
